// File: rtl/tx_ctrl_pkg.sv
// Shared types for the TX frame sequencer: FSM state encoding and grant encoding.
package tx_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } grant_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: one-hot grant, pointer moves to the other side of each accepted winner.
module rr_arbiter_2
  import tx_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  grant_t ptr;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (ptr == GNT_B) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= GNT_A;
    end else if (accept && (gnt != 2'b00)) begin
      ptr <= gnt[0] ? GNT_B : GNT_A;
    end
  end

endmodule

// File: rtl/tx_frame_sequencer.sv
// Arbitrates two word requesters and drives the TX shift register's parallel word, load and shift strobes.
module tx_frame_sequencer
  import tx_ctrl_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int FRAME_BITS = 32,
  parameter int GAP_CYCLES = 2,
  parameter int CNT_W      = 6
) (
  input  logic              scl,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ack,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ack,
  input  logic              abort,
  output logic [DATA_W-1:0] tx_word,
  output logic              load_rdata,
  output logic              enable_desp,
  output logic              grant_b,
  output logic              busy,
  output logic              frame_done,
  output logic              aborted
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_GAP = CNT_W'(GAP_CYCLES - 1);
  localparam state_t AFTER_FRAME = (GAP_CYCLES == 0) ? IDLE : GAP;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [1:0]       gnt;
  logic             arb_accept;
  logic             last_q, last_next;
  logic             load_next, en_next, done_next, abort_next, a_ack_next, b_ack_next;

  rr_arbiter_2 u_arb (
    .clk    (scl),
    .rst    (rst),
    .req    ({b_valid, a_valid}),
    .accept (arb_accept),
    .gnt    (gnt)
  );

  // The state runs one cycle ahead of the registered strobes, so the strobe seen on the
  // shift register's negedge always matches the phase the FSM has just left.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    arb_accept = 1'b0;
    last_next  = 1'b0;
    load_next  = 1'b0;
    en_next    = 1'b0;
    done_next  = 1'b0;
    abort_next = 1'b0;
    a_ack_next = 1'b0;
    b_ack_next = 1'b0;
    unique case (state)
      IDLE: begin
        if (gnt != 2'b00) begin
          arb_accept = 1'b1;
          a_ack_next = gnt[0];
          b_ack_next = gnt[1];
          state_next = LOAD;
        end
      end
      LOAD: begin
        cnt_next = '0;
        if (abort) begin
          abort_next = 1'b1;
          state_next = AFTER_FRAME;
        end else begin
          load_next  = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          abort_next = 1'b1;
          cnt_next   = '0;
          state_next = AFTER_FRAME;
        end else begin
          en_next = 1'b1;
          if (cnt == LAST_BIT) begin
            last_next  = 1'b1;
            cnt_next   = '0;
            state_next = AFTER_FRAME;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end
      GAP: begin
        if (cnt == LAST_GAP) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    // The final shift strobe is still on the wire while last_q is set; an abort there wins.
    if (last_q) begin
      if (abort) abort_next = 1'b1;
      else       done_next  = 1'b1;
    end
  end

  always_ff @(posedge scl) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      last_q      <= 1'b0;
      a_ack       <= 1'b0;
      b_ack       <= 1'b0;
      tx_word     <= '0;
      grant_b     <= 1'b0;
      load_rdata  <= 1'b0;
      enable_desp <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      aborted     <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      last_q      <= last_next;
      a_ack       <= a_ack_next;
      b_ack       <= b_ack_next;
      load_rdata  <= load_next;
      enable_desp <= en_next;
      busy        <= (state_next != IDLE);
      frame_done  <= done_next;
      aborted     <= abort_next;
      if (arb_accept) begin
        tx_word <= gnt[1] ? b_data : a_data;
        grant_b <= gnt[1];
      end
    end
  end

endmodule
